// File: rtl/gray_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module  : gray_stream_decoder
// Brief   : Decodes a sampled Gray count to binary and tracks step legality
//           with an INIT/LOCK/FAULT lock monitor. Optional macro: GRAY_DOWN_EN
// Revision: 1.0  initial release
// ============================================================================
module gray_stream_decoder #(
  parameter int WIDTH  = 4,
  parameter int RELOCK = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic             locked,
  output logic             step_err,
  output logic             wrap,
  output logic [7:0]       err_cnt
);

  localparam int RW = $clog2(RELOCK + 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [RW-1:0]    relock_q, relock_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             step_err_q, step_err_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] dec;
  logic [7:0]       err_sat;
  logic             is_up, is_down, is_hold, is_step, is_wrap;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = ^(gray_in >> i);
    end
  end

  // bin_q doubles as the previous-sample reference.
  assign is_up   = (dec == bin_q + WIDTH'(1));
  assign is_hold = (dec == bin_q);
`ifdef GRAY_DOWN_EN
  assign is_down = (dec == bin_q - WIDTH'(1));
  assign is_wrap = (is_up && (&bin_q)) || (is_down && ~(|bin_q));
`else
  assign is_down = 1'b0;
  assign is_wrap = is_up && (&bin_q);
`endif
  assign is_step = is_up || is_down;
  assign err_sat = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    relock_d    = relock_q;
    err_cnt_d   = err_cnt_q;
    out_valid_d = 1'b0;
    step_err_d  = 1'b0;
    wrap_d      = 1'b0;
    if (in_valid) begin
      bin_d       = dec;
      out_valid_d = 1'b1;
      case (state_q)
        ST_INIT: begin
          state_d  = ST_LOCK;
          relock_d = '0;
        end
        ST_LOCK: begin
          if (is_step || is_hold) begin
            wrap_d = is_wrap;
          end else begin
            step_err_d = 1'b1;
            err_cnt_d  = err_sat;
            relock_d   = '0;
            state_d    = ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (is_step) begin
            if (relock_q == RW'(RELOCK - 1)) begin
              state_d  = ST_LOCK;
              relock_d = '0;
            end else begin
              relock_d = relock_q + RW'(1);
            end
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            err_cnt_d  = err_sat;
            relock_d   = '0;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      bin_q       <= '0;
      relock_q    <= '0;
      err_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      relock_q    <= relock_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= out_valid_d;
      step_err_q  <= step_err_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == ST_LOCK);
  assign step_err  = step_err_q;
  assign wrap      = wrap_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_gray_stream_decoder
// Brief   : Scoreboard bench for gray_stream_decoder (WIDTH=4, RELOCK=3)
// Revision: 1.0  initial release
// ============================================================================
module tb_gray_stream_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] gray_in = 4'd0;
  logic       in_valid = 1'b0;
  logic [3:0] bin_out;
  logic       out_valid, locked, step_err, wrap;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] bin;
    logic       lk;
    logic       se;
    logic       wr;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];

  gray_stream_decoder #(.WIDTH(4), .RELOCK(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .gray_in  (gray_in),
    .in_valid (in_valid),
    .bin_out  (bin_out),
    .out_valid(out_valid),
    .locked   (locked),
    .step_err (step_err),
    .wrap     (wrap),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Outputs packed as {bin, locked, step_err, wrap, err_cnt}
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1 expected no output");
          end else begin
            e = q.pop_front();
            chk(e.name, {17'd0, bin_out, locked, step_err, wrap, err_cnt},
                {17'd0, e.bin, e.lk, e.se, e.wr, e.cnt});
          end
        end else begin
          chk("idle_pulses", {30'd0, step_err, wrap}, 32'd0);
        end
      end
    end
  end

  task automatic send(input string nm, input logic [3:0] g, input logic [3:0] b,
                      input logic lk, input logic se, input logic wr, input logic [7:0] cnt);
    exp_t e;
    e.name = nm; e.bin = b; e.lk = lk; e.se = se; e.wr = wr; e.cnt = cnt;
    q.push_back(e);
    gray_in  = g;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle so the clear must be asynchronous.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #2;
    chk({nm, "_queue_drained"}, q.size(), 32'd0);
    reset = 1'b1;
    #1;
    chk({nm, "_outs_zero"}, {17'd0, bin_out, out_valid, locked, step_err, wrap, err_cnt}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    reset = 1'b1;
    #1;
    chk("reset_outs_zero", {17'd0, bin_out, out_valid, locked, step_err, wrap, err_cnt}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Basic counting from reset
    send("t1_g0000", 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    send("t1_g0001", 4'b0001, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    send("t1_g0011", 4'b0011, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0);
    send("t1_g0010", 4'b0010, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(2);

    // Wrap 15 -> 0, then a +2 jump and relock
    do_reset("t2");
    send("t2_g1000", 4'b1000, 4'd15, 1'b1, 1'b0, 1'b0, 8'd0);
    send("t2_wrap",  4'b0000, 4'd0,  1'b1, 1'b0, 1'b1, 8'd0);
    send("t3_g0001", 4'b0001, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
    send("t3_g0011", 4'b0011, 4'd2,  1'b1, 1'b0, 1'b0, 8'd0);
    send("t3_bad",   4'b0110, 4'd4,  1'b0, 1'b1, 1'b0, 8'd1);
    send("t3_rl1",   4'b0111, 4'd5,  1'b0, 1'b0, 1'b0, 8'd1);
    send("t3_hold",  4'b0111, 4'd5,  1'b0, 1'b0, 1'b0, 8'd1);
    send("t3_rl2",   4'b0101, 4'd6,  1'b0, 1'b0, 1'b0, 8'd1);
    send("t3_rl3",   4'b0100, 4'd7,  1'b1, 1'b0, 1'b0, 8'd1);
    idle(2);

    // Holds with in_valid gaps
    do_reset("t4");
    send("t4_h1", 4'b0010, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(2);
    send("t4_h2", 4'b0010, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(1);
    send("t4_h3", 4'b0010, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(1);

    // Async reset while in FAULT, then fresh reference
    send("t5_bad", 4'b1000, 4'd15, 1'b0, 1'b1, 1'b0, 8'd1);
    do_reset("t5");
    send("t5_g0101", 4'b0101, 4'd6, 1'b1, 1'b0, 1'b0, 8'd0);

    // 256 alternating bad samples: bin 8 / bin 0
    for (int i = 0; i < 256; i++) begin
      send("t6_sat", (i % 2 == 0) ? 4'b1100 : 4'b0000, (i % 2 == 0) ? 4'd8 : 4'd0,
           1'b0, 1'b1, 1'b0, (i < 255) ? 8'(i + 1) : 8'd255);
    end
    idle(2);

    // Down step 0 -> 15 while locked
    do_reset("t7");
    send("t7_g0000", 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
`ifdef GRAY_DOWN_EN
    send("t7_down", 4'b1000, 4'd15, 1'b1, 1'b0, 1'b1, 8'd0);
`else
    send("t7_down", 4'b1000, 4'd15, 1'b0, 1'b1, 1'b0, 8'd1);
`endif
    idle(3);
    chk("final_queue_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
